// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular-buffer queue of {instruction, fetch PC} pairs
// that sits between instruction memory and decode.
//
// Both ports use valid/ready handshakes. A transfer happens on a rising edge
// when valid && ready are both high. The source holds its payload stable
// while valid && !ready. in_ready is simply !full, so it does not depend on
// a same-cycle pop.
//
// Optional feature: define IFQ_BYPASS_EN to let an incoming word reach
// out_* in the same cycle when the queue is empty. The default build has no
// combinational path from in_* to out_*.
module instr_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            flush,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty,
  output logic            overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic            push;
  logic            pop;
  logic            byp_take;

  // Status flags come only from registered occupancy.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;
  assign overflow = overflow_q;

  // Head presentation. Under bypass, an empty queue forwards the incoming word.
  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
    byp_take  = 1'b0;
    if (!empty) begin
      out_valid = 1'b1;
      out_instr = instr_mem[rd_ptr];
      out_pc    = pc_mem[rd_ptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (in_valid && !flush) begin
      out_valid = 1'b1;
      out_instr = in_instr;
      out_pc    = in_pc;
      byp_take  = out_ready;
    end
`endif
  end

  // Flush overrides both sides. A word consumed by bypass is never stored.
  always_comb begin
    push = in_valid && in_ready && !flush && !byp_take;
    pop  = !empty && out_ready && !flush;
  end

  // Storage array. Only reset clears it; flush leaves contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointers, occupancy and sticky overflow. Flush returns all of them to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (in_valid && full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction fetch queue for the multicycle core. It captures {instruction, fetch PC} pairs returned from instruction memory and holds up to DEPTH of them. It presents them in order to decode over a valid/ready handshake. It generalises the single-entry instruction register with depth, configurable width, flush, occupancy reporting and an optional empty-queue bypass.

## Interface
Parameters:
- XLEN, 32, width of instruction and PC fields
- DEPTH, 4, number of entries; power of two, minimum 2
- CW, $clog2(DEPTH)+1, width of count (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  fetch presents a returned instruction (replaces IRWrite)
- in_ready  out  1  queue accepts a push; equals !full
- in_instr  in  XLEN  instruction word from memory read data
- in_pc  in  XLEN  PC the word was fetched from
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes the head entry
- out_instr  out  XLEN  head instruction
- out_pc  out  XLEN  head PC (the OldPC of the entry)
- flush  in  1  discard all entries (taken branch/jump, trap)
- count  out  CW  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: in_valid seen while full; cleared only by reset or flush

## Operation
- Circular buffer: storage array, wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count register.
- Push: in_valid && in_ready writes {in_instr, in_pc} at wr_ptr and increments wr_ptr.
- Pop: out_valid && out_ready increments rd_ptr.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: in_ready = 0 even if a pop occurs in the same cycle. No push while full. in_valid while full is dropped and sets overflow.
- Empty (bypass not compiled): out_valid = 0, out_instr = 0, out_pc = 0.
- Non-empty: out_valid = 1, and out_instr/out_pc come combinationally from the entry at rd_ptr.
- Flush has highest priority. Next cycle: pointers = 0, count = 0, overflow = 0.
  - A same-cycle push or pop is ignored.
  - Storage contents are not cleared.
- out_instr/out_pc are stable while out_valid && !out_ready, unless a flush occurs.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, overflow = 0, storage cleared to 0.
  - Outputs during and after reset: in_ready = 1, out_valid = 0, out_instr = 0, out_pc = 0, full = 0, empty = 1.
  - Reset mid-operation discards all entries immediately.
- Latency, bypass not compiled: push in cycle N → out_valid = 1 in cycle N+1 with that entry.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- full, empty and count are registered-state derived and reflect the state after the previous edge.
- Wrap: after DEPTH pushes and DEPTH pops, pointers return to 0 with no discontinuity in order.

## Configuration
- IFQ_BYPASS_EN defined: when empty and in_valid, out_valid = 1 and out_instr/out_pc = in_instr/in_pc in the same cycle (zero latency).
  - If out_ready is also 1, the entry is consumed without being written; count stays 0.
  - Otherwise the entry is pushed normally.
  - flush suppresses the bypass: out_valid = 0.
- IFQ_BYPASS_EN undefined: no combinational path from in_* to out_*; minimum latency is 1 cycle.

## Test plan
- Reset: assert rst_n = 0 mid-stream with count = 3 → count = 0, empty = 1, out_valid = 0, out_instr = 0, out_pc = 0, with no clock edge needed.
- Fill/drain, DEPTH = 4, out_ready = 0: push instr 0x00500093..0x00800093 with PC 0x0..0xC → full = 1, in_ready = 0. Then out_ready = 1 → four pops in order with PC 0x0, 0x4, 0x8, 0xC; then empty = 1.
- Overflow: while full, in_valid = 1 with 0xDEADBEEF → count stays 4, overflow = 1, entry never appears on out_*.
- Simultaneous push/pop: at count = 2, push 0x00A00113 and pop in the same cycle → count = 2, next head is the old second entry. Repeat 10 times to exercise wraparound; order is preserved.
- Flush: at count = 3, flush = 1 with in_valid = 1 and out_ready = 1 → next cycle count = 0, overflow = 0, pushed word absent.
- Bypass (IFQ_BYPASS_EN): empty, in_valid = 1, in_instr = 0x00000013, in_pc = 0x100, out_ready = 1 → out_valid = 1 the same cycle with those values; count remains 0. Without the macro, the same stimulus gives out_valid = 1 one cycle later.
